// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash init loader.
package spi_flash_pkg;
  localparam int IMG_AW   = 21;
  localparam int FLASH_AW = 24;
  localparam logic [7:0] READ_OP = 8'h03;

  typedef enum logic [2:0] {
    IDLE, CMD, DATA, PRESENT, HOLD, DESEL
  } state_t;

  // Image addresses sit at a fixed offset in flash; the sum wraps at 24 bits.
  function automatic logic [FLASH_AW-1:0] flash_addr(input logic [FLASH_AW-1:0] base,
                                                     input logic [IMG_AW-1:0] a);
    return base + {{(FLASH_AW-IMG_AW){1'b0}}, a};
  endfunction
endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit engine: SCK generation, MSB-first TX shift and RX capture.
module spi_shift_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [5:0]  i_nbits,
  input  logic [31:0] i_tx,
  input  logic        i_miso,
  output logic        o_sck,
  output logic        o_mosi,
  output logic        o_done,
  output logic [7:0]  o_rx
);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic        r_active;
  logic        r_sck;
  logic [3:0]  r_div;
  logic [5:0]  r_bits;
  logic [31:0] r_shreg;
  logic [7:0]  r_rx;
  logic        w_edge;

  assign w_edge = r_active && (r_div == DIV_LAST);
  assign o_done = w_edge && r_sck && (r_bits == 6'd1);
  assign o_sck  = r_sck;
  assign o_mosi = r_active & r_shreg[31];
  assign o_rx   = r_rx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_sck    <= 1'b0;
      r_div    <= 4'd0;
      r_bits   <= 6'd0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_sck    <= 1'b0;
      r_div    <= 4'd0;
      r_bits   <= i_nbits;
    end else if (w_edge) begin
      r_div <= 4'd0;
      r_sck <= ~r_sck;
      // A bit completes on its falling edge.
      if (r_sck) begin
        r_bits <= r_bits - 6'd1;
        if (r_bits == 6'd1) r_active <= 1'b0;
      end
    end else if (r_active) begin
      r_div <= r_div + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_start) r_shreg <= i_tx;
    else if (w_edge && r_sck) r_shreg <= {r_shreg[30:0], 1'b0};
    if (w_edge && !r_sck) r_rx <= {r_rx[6:0], i_miso};
  end
endmodule

// File: rtl/spi_flash_init_loader.sv
// Fetches single image bytes from SPI flash; keeps CS low between requests
// so that sequential addresses stream without a new READ command.
module spi_flash_init_loader
  import spi_flash_pkg::*;
#(
  parameter logic [FLASH_AW-1:0] FLASH_BASE = 24'h100000,
  parameter logic [IMG_AW-1:0]   IMAGE_LAST = 21'h1FFFFF,
  parameter int                  CLK_DIV    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  input  logic [IMG_AW-1:0] init_address,
  output logic [7:0]        init_data,
  output logic              init_ready,
  output logic [IMG_AW-1:0] init_stop,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              busy
);
  localparam logic [6:0] DESEL_LAST = 7'(4*CLK_DIV - 1);
  localparam logic [6:0] DESEL_GO   = 7'(4*CLK_DIV);

  state_t            r_state, w_next;
  logic [IMG_AW-1:0] r_addr, r_next, r_pend_addr;
  logic              r_wrap, r_pend, r_cs_n, r_ready;
  logic [6:0]        r_cnt;
  logic [7:0]        r_data;

  logic              w_start, w_done, w_cap, w_cs_low, w_cs_high, w_present, w_pend_clr;
  logic [5:0]        w_nbits;
  logic [31:0]       w_tx;
  logic [7:0]        w_rx;
  logic              w_req, w_hit;
  logic [IMG_AW-1:0] w_req_addr, w_cap_addr;

  // A fresh request wins over a parked one.
  assign w_req      = init_req | r_pend;
  assign w_req_addr = init_req ? init_address : r_pend_addr;
  assign w_hit      = (w_req_addr == r_next) && !r_wrap;

  assign busy       = (r_state != IDLE) && (r_state != HOLD);
  assign init_stop  = IMAGE_LAST;
  assign init_data  = r_data;
  assign init_ready = r_ready;
  assign spi_cs_n   = r_cs_n;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_nbits    = 6'd32;
    w_tx       = 32'h0;
    w_cap      = 1'b0;
    w_cap_addr = init_address;
    w_cs_low   = 1'b0;
    w_cs_high  = 1'b0;
    w_present  = 1'b0;
    w_pend_clr = 1'b0;
    case (r_state)
      IDLE: if (init_req) begin
        w_next   = CMD;
        w_cap    = 1'b1;
        w_cs_low = 1'b1;
        w_start  = 1'b1;
        w_tx     = {READ_OP, flash_addr(FLASH_BASE, init_address)};
      end
      CMD: if (w_done) begin
        w_next  = DATA;
        w_start = 1'b1;
        w_nbits = 6'd8;
      end
      DATA:    if (w_done) w_next = PRESENT;
      PRESENT: begin
        w_next    = HOLD;
        w_present = 1'b1;
      end
      HOLD: if (w_req) begin
        w_cap      = 1'b1;
        w_cap_addr = w_req_addr;
        w_pend_clr = 1'b1;
        if (w_hit) begin
          w_next  = DATA;
          w_start = 1'b1;
          w_nbits = 6'd8;
        end else begin
          w_next    = DESEL;
          w_cs_high = 1'b1;
        end
      end
      DESEL: begin
        // CS drops one cycle ahead of the first command clock.
        if (r_cnt == DESEL_LAST) w_cs_low = 1'b1;
        if (r_cnt == DESEL_GO) begin
          w_next  = CMD;
          w_start = 1'b1;
          w_tx    = {READ_OP, flash_addr(FLASH_BASE, r_addr)};
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_n <= 1'b1;
      r_ready <= 1'b0;
      r_data <= 8'h00;
      r_next <= '0;
      r_wrap <= 1'b0;
      r_pend <= 1'b0;
      r_cnt  <= 7'd0;
    end else begin
      r_ready <= w_present;
      if (w_present) begin
        r_data <= w_rx;
        r_next <= r_addr + 21'd1;
        r_wrap <= (r_addr == {IMG_AW{1'b1}});
      end
      if (w_cs_low)       r_cs_n <= 1'b0;
      else if (w_cs_high) r_cs_n <= 1'b1;
      r_cnt <= (r_state == DESEL) ? r_cnt + 7'd1 : 7'd0;
      if (busy && init_req) r_pend <= 1'b1;
      else if (w_pend_clr)  r_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap) r_addr <= w_cap_addr;
    if (busy && init_req) r_pend_addr <= init_address;
  end

  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_nbits (w_nbits),
    .i_tx    (w_tx),
    .i_miso  (spi_miso),
    .o_sck   (spi_sck),
    .o_mosi  (spi_mosi),
    .o_done  (w_done),
    .o_rx    (w_rx)
  );
endmodule

// File: tb/tb_spi_flash_init_loader.sv
// Bench for spi_flash_init_loader: SPI flash model, transaction-level expectation queue.
module tb_spi_flash_init_loader;
  localparam int D        = 2;
  localparam int LAT_IDLE = 80*D + 2;
  localparam int LAT_HIT  = 16*D + 2;
  localparam int LAT_MISS = 84*D + 3;
  localparam logic [23:0] BASE0 = 24'h100000;

  logic clk = 1'b0;
  logic rst, init_req, req2;
  logic [20:0] init_address, addr2, init_stop, stop2;
  logic [7:0] init_data, data2;
  logic init_ready, ready2, busy, busy2;
  logic cs0, sck0, mosi0, miso0, cs1, sck1, mosi1, miso1;

  spi_flash_init_loader dut (
    .clk(clk), .rst(rst), .init_req(init_req), .init_address(init_address),
    .init_data(init_data), .init_ready(init_ready), .init_stop(init_stop),
    .spi_cs_n(cs0), .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(miso0), .busy(busy)
  );

  spi_flash_init_loader #(.FLASH_BASE(24'hFFFFFF)) dut_wrap (
    .clk(clk), .rst(rst), .init_req(req2), .init_address(addr2),
    .init_data(data2), .init_ready(ready2), .init_stop(stop2),
    .spi_cs_n(cs1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso1), .busy(busy2)
  );

  initial forever #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, ready_cnt = 0, t_req = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (a == 24'h100000) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Flash model: READ command decode, continuous MSB-first output.
  int rises[2], obit[2], cs_rises[2], high_run[2], last_high[2], cmd_cnt[2];
  logic [31:0] cmd[2], last_cmd[2];
  logic [23:0] faddr[2];
  bit have_cmd[2], prev_sck[2], prev_cs[2];

  initial begin
    logic c, s, m, o;
    logic [7:0] b;
    miso0 = 1'b0;
    miso1 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rises[k] = 0; obit[k] = 0; cs_rises[k] = 0; high_run[k] = 0; last_high[k] = 0;
      cmd_cnt[k] = 0; cmd[k] = '0; last_cmd[k] = '0; faddr[k] = '0;
      have_cmd[k] = 0; prev_sck[k] = 0; prev_cs[k] = 1;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        c = (k == 0) ? cs0 : cs1;
        s = (k == 0) ? sck0 : sck1;
        m = (k == 0) ? mosi0 : mosi1;
        o = (k == 0) ? miso0 : miso1;
        if (c) begin
          if (!prev_cs[k]) cs_rises[k]++;
          high_run[k]++;
          rises[k] = 0;
          have_cmd[k] = 0;
          o = 1'b0;
        end else begin
          if (prev_cs[k]) begin
            last_high[k] = high_run[k];
            high_run[k] = 0;
          end
          if (s && !prev_sck[k] && !have_cmd[k]) begin
            cmd[k] = {cmd[k][30:0], m};
            rises[k]++;
            if (rises[k] == 32) begin
              have_cmd[k] = 1;
              last_cmd[k] = cmd[k];
              cmd_cnt[k]++;
              faddr[k] = cmd[k][23:0];
              obit[k] = 0;
            end
          end
          if (!s && prev_sck[k] && have_cmd[k]) begin
            if (obit[k] == 8) begin
              faddr[k] = faddr[k] + 24'd1;
              obit[k] = 0;
            end
            b = mem_byte(faddr[k]);
            o = b[3'(7 - obit[k])];
            obit[k]++;
          end
        end
        prev_sck[k] = s;
        prev_cs[k] = c;
        if (k == 0) miso0 = o;
        else        miso1 = o;
      end
    end
  end

  // Transaction model: expected byte and latency for each request.
  typedef struct { logic [7:0] d; int c; int lat; } exp_t;
  exp_t exp_q[$];
  bit m_valid = 0, m_wrap = 0;
  logic [20:0] m_next = '0;

  task automatic issue(input logic [20:0] a, input bit pend);
    exp_t e;
    logic [23:0] fa;
    int lat;
    if (!m_valid) lat = LAT_IDLE;
    else if (a == m_next && !m_wrap) lat = LAT_HIT;
    else lat = LAT_MISS;
    if (pend) lat = -1;
    m_valid = 1;
    m_next = a + 21'd1;
    m_wrap = (a == 21'h1FFFFF);
    fa = BASE0 + {3'b000, a};
    @(posedge clk);
    #1;
    init_req = 1'b1;
    init_address = a;
    t_req = cyc;
    e.d = mem_byte(fa);
    e.c = cyc;
    e.lat = lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1 init_req = 1'b0;
  endtask

  task automatic wait_ready(output int rc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!init_ready && n < 1000);
    chk("ready_within_bound", init_ready, 1'b1);
    rc = cyc;
  endtask

  initial begin
    exp_t e;
    bit prev_rdy = 0;
    forever begin
      @(negedge clk);
      if (init_ready) begin
        chk("ready_gap", prev_rdy, 1'b0);
        ready_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: pulse at cycle %0d, required none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("init_data", init_data, e.d);
          if (e.lat >= 0) chk("latency", cyc - e.c, e.lat);
        end
      end
      prev_rdy = init_ready;
    end
  end

  initial begin
    int rc, r1, r2, t1, cc, cr, n;
    rst = 1'b1; init_req = 1'b0; init_address = '0; req2 = 1'b0; addr2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", cs0, 1'b1);
    chk("rst_sck", sck0, 1'b0);
    chk("rst_mosi", mosi0, 1'b0);
    chk("rst_ready", init_ready, 1'b0);
    chk("rst_data", init_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_busy_wrap", busy2, 1'b0);
    chk("init_stop", init_stop, 21'h1FFFFF);
    chk("init_stop_wrap", stop2, 21'h1FFFFF);
    @(posedge clk);
    #1 rst = 1'b0;

    // Cold read from IDLE.
    issue(21'h0, 0);
    wait_ready(rc);
    chk("cold_cmd", last_cmd[0], 32'h03100000);
    chk("cold_data", init_data, 8'hA5);
    chk("cold_latency", rc - t_req, 162);

    // Streaming hits.
    cr = cs_rises[0];
    cc = cmd_cnt[0];
    for (int a = 1; a <= 3; a++) begin
      issue(21'(a), 0);
      wait_ready(rc);
      chk("stream_latency", rc - t_req, 34);
    end
    chk("stream_no_cs_rise", cs_rises[0], cr);
    chk("stream_no_cmd", cmd_cnt[0], cc);

    // Miss from HOLD.
    issue(21'h00400, 0);
    wait_ready(rc);
    chk("miss_cs_high", last_high[0], 8);
    chk("miss_cmd", last_cmd[0], 32'h03100400);
    chk("miss_latency", rc - t_req, 171);
    chk("miss_cs_rise", cs_rises[0], cr + 1);

    // Request parked while DATA is running.
    cc = cmd_cnt[0];
    n = ready_cnt;
    issue(21'h00401, 0);
    t1 = t_req;
    repeat (8) @(posedge clk);
    chk("pend_issued_busy", busy, 1'b1);
    issue(21'h00402, 1);
    wait_ready(r1);
    chk("pend_first_latency", r1 - t1, 34);
    wait_ready(r2);
    chk("pend_service_gap", r2 - r1, 34);
    repeat (100) @(negedge clk);
    chk("pend_ready_count", ready_cnt - n, 2);
    chk("pend_no_cmd", cmd_cnt[0], cc);

    // next_addr wrap forces a fresh command.
    issue(21'h1FFFFF, 0);
    wait_ready(rc);
    chk("top_cmd", last_cmd[0], 32'h032FFFFF);
    cc = cmd_cnt[0];
    issue(21'h0, 0);
    wait_ready(rc);
    chk("wrap_new_cmd", cmd_cnt[0], cc + 1);
    chk("wrap_cmd", last_cmd[0], 32'h03100000);
    chk("wrap_latency", rc - t_req, 171);

    // Reset in the middle of the command phase.
    issue(21'h5, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rises[0] < 20 && n < 2000);
    chk("abort_reached_bit20", (rises[0] >= 20), 1'b1);
    rst = 1'b1;
    exp_q.delete();
    m_valid = 0;
    @(negedge clk);
    chk("abort_cs_n", cs0, 1'b1);
    chk("abort_sck", sck0, 1'b0);
    chk("abort_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    n = ready_cnt;
    repeat (300) @(negedge clk);
    chk("abort_no_ready", ready_cnt, n);
    cc = cmd_cnt[0];
    issue(21'h7, 0);
    wait_ready(rc);
    chk("restart_latency", rc - t_req, 162);
    chk("restart_cmd", last_cmd[0], 32'h03100007);
    chk("restart_cmd_count", cmd_cnt[0], cc + 1);

    // FLASH_BASE wrap on the second instance.
    @(posedge clk);
    #1;
    req2 = 1'b1;
    addr2 = 21'h1;
    t1 = cyc;
    @(posedge clk);
    #1 req2 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready2 && n < 1000);
    chk("base_wrap_ready", ready2, 1'b1);
    chk("base_wrap_latency", cyc - t1, 162);
    chk("base_wrap_cmd", last_cmd[1], 32'h03000000);
    chk("base_wrap_data", data2, 8'h5A);

    repeat (50) @(negedge clk);
    chk("outstanding_requests", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
